header_tuple_extractor: RTL and testbench

// Parametrised successor to the single-beat header engine: sits in the NetFPGA-10G datapath between input arbiter and

---
 rtl/header_tuple_extractor.sv | 213 +++++++++++++++++++++
 tb/tb_header_tuple_extractor.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/header_tuple_extractor.sv
// Buffers the leading header beats of each packet and extracts the IPv4 5-tuple onto a sideband.
// Optional build macro HDR_VLAN_EN: parse one 802.1Q tag ahead of the IPv4 ethertype.
module header_tuple_extractor #(
   parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
   parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
   parameter int unsigned CNT_WIDTH            = 32
) (
   input  logic                              axi_aclk,
   input  logic                              axi_reset,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   input  logic                              s_axis_tlast,
   output logic                              s_axis_tready,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   output logic                              m_axis_tlast,
   input  logic                              m_axis_tready,
   output logic [103:0]                      m_hdr_tuple,
   output logic                              m_hdr_valid,
   input  logic                              cfg_drop_non_ip,
   input  logic                              stat_clear,
   output logic [CNT_WIDTH-1:0]              stat_pkt_cnt,
   output logic [CNT_WIDTH-1:0]              stat_drop_cnt
);

   localparam int unsigned W  = C_S_AXIS_DATA_WIDTH;
   localparam int unsigned SW = W / 8;
   localparam int unsigned TU = C_S_AXIS_TUSER_WIDTH;
`ifdef HDR_VLAN_EN
   localparam int unsigned HDR_BYTES = 42;
`else
   localparam int unsigned HDR_BYTES = 38;
`endif
   localparam int unsigned HDR_BEATS = (HDR_BYTES * 8 + W - 1) / W;
   localparam int unsigned IDX_W     = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
   localparam int unsigned HDR_W     = HDR_BEATS * W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HDR_BEATS - 1);

   typedef enum logic [2:0] {StCapture, StParse, StFlush, StPass, StDrop} state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
   logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
   logic [IDX_W-1:0]   last_idx_q, last_idx_d;
   logic [103:0]       tuple_q, tuple_d;

   logic [W-1:0]       buf_data_q [HDR_BEATS];
   logic [SW-1:0]      buf_strb_q [HDR_BEATS];
   logic [TU-1:0]      buf_user_q [HDR_BEATS];
   logic               buf_last_q [HDR_BEATS];

   logic [HDR_W-1:0]   hdr_flat;
   logic               plain_ip, short_pkt, is_ip;
   logic [103:0]       tuple_c;
   logic               drop_inc, pkt_inc;

   // Byte k of the buffered header; byte 0 is the MSB of beat 0.
   function automatic logic [7:0] hb(input logic [HDR_W-1:0] h, input int unsigned k);
      hb = h[HDR_W-1-8*k -: 8];
   endfunction

   // Tuple fields for an IPv4 header starting at byte 14+o; ports only for TCP/UDP.
   function automatic logic [103:0] fields(input logic [HDR_W-1:0] h, input int unsigned o);
      logic [7:0]  proto;
      logic [31:0] ports;
      proto = hb(h, 23 + o);
      ports = {hb(h, 34 + o), hb(h, 35 + o), hb(h, 36 + o), hb(h, 37 + o)};
      if (proto != 8'd6 && proto != 8'd17) ports = '0;
      fields = {hb(h, 26 + o), hb(h, 27 + o), hb(h, 28 + o), hb(h, 29 + o),
                hb(h, 30 + o), hb(h, 31 + o), hb(h, 32 + o), hb(h, 33 + o), proto, ports};
   endfunction

   always_comb begin
      hdr_flat = '0;
      for (int i = 0; i < HDR_BEATS; i++) hdr_flat[(HDR_BEATS-1-i)*W +: W] = buf_data_q[i];
   end

   always_comb begin
      short_pkt = (last_idx_q != LAST_IDX);
      plain_ip  = hb(hdr_flat, 12) == 8'h08 && hb(hdr_flat, 13) == 8'h00 &&
                  hb(hdr_flat, 14) == 8'h45;
`ifdef HDR_VLAN_EN
      begin
         logic vlan_ip;
         vlan_ip = hb(hdr_flat, 12) == 8'h81 && hb(hdr_flat, 13) == 8'h00 &&
                   hb(hdr_flat, 16) == 8'h08 && hb(hdr_flat, 17) == 8'h00 &&
                   hb(hdr_flat, 18) == 8'h45;
         is_ip   = !short_pkt && (plain_ip || vlan_ip);
         tuple_c = !is_ip ? '0 : (vlan_ip ? fields(hdr_flat, 4) : fields(hdr_flat, 0));
      end
`else
      is_ip   = !short_pkt && plain_ip;
      tuple_c = is_ip ? fields(hdr_flat, 0) : '0;
`endif
   end

   always_comb begin
      state_d       = state_q;
      wr_idx_d      = wr_idx_q;
      rd_idx_d      = rd_idx_q;
      last_idx_d    = last_idx_q;
      tuple_d       = tuple_q;
      drop_inc      = 1'b0;
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tstrb  = '0;
      m_axis_tuser  = '0;
      m_axis_tlast  = 1'b0;
      m_hdr_valid   = 1'b0;
      m_hdr_tuple   = '0;
      unique case (state_q)
         StCapture: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid) begin
               wr_idx_d   = wr_idx_q + 1'b1;
               last_idx_d = wr_idx_q;
               if (s_axis_tlast || wr_idx_q == LAST_IDX) begin
                  wr_idx_d = '0;
                  state_d  = StParse;
               end
            end
         end
         StParse: begin
            tuple_d  = tuple_c;
            rd_idx_d = '0;
            if (!is_ip && cfg_drop_non_ip) begin
               drop_inc = 1'b1;
               state_d  = StDrop;
            end else begin
               state_d = StFlush;
            end
         end
         StFlush: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = buf_data_q[rd_idx_q];
            m_axis_tstrb  = buf_strb_q[rd_idx_q];
            m_axis_tuser  = buf_user_q[rd_idx_q];
            m_axis_tlast  = buf_last_q[rd_idx_q];
            m_hdr_valid   = (rd_idx_q == '0);
            m_hdr_tuple   = (rd_idx_q == '0) ? tuple_q : '0;
            if (m_axis_tready) begin
               if (rd_idx_q == last_idx_q) begin
                  state_d = buf_last_q[rd_idx_q] ? StCapture : StPass;
               end else begin
                  rd_idx_d = rd_idx_q + 1'b1;
               end
            end
         end
         StPass: begin
            s_axis_tready = m_axis_tready;
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tdata  = s_axis_tdata;
            m_axis_tstrb  = s_axis_tstrb;
            m_axis_tuser  = s_axis_tuser;
            m_axis_tlast  = s_axis_tlast;
            if (s_axis_tvalid && m_axis_tready && s_axis_tlast) state_d = StCapture;
         end
         StDrop: begin
            if (buf_last_q[last_idx_q]) begin
               state_d = StCapture;
            end else begin
               s_axis_tready = 1'b1;
               if (s_axis_tvalid && s_axis_tlast) state_d = StCapture;
            end
         end
         default: state_d = StCapture;
      endcase
   end

   assign pkt_inc = s_axis_tvalid && s_axis_tready && s_axis_tlast;

   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         state_q    <= StCapture;
         wr_idx_q   <= '0;
         rd_idx_q   <= '0;
         last_idx_q <= '0;
         tuple_q    <= '0;
      end else begin
         state_q    <= state_d;
         wr_idx_q   <= wr_idx_d;
         rd_idx_q   <= rd_idx_d;
         last_idx_q <= last_idx_d;
         tuple_q    <= tuple_d;
      end
   end

   // Header buffer holds no control state, so it needs no reset.
   always_ff @(posedge axi_aclk) begin
      if (state_q == StCapture && s_axis_tvalid) begin
         buf_data_q[wr_idx_q] <= s_axis_tdata;
         buf_strb_q[wr_idx_q] <= s_axis_tstrb;
         buf_user_q[wr_idx_q] <= s_axis_tuser;
         buf_last_q[wr_idx_q] <= s_axis_tlast;
      end
   end

   always_ff @(posedge axi_aclk) begin
      if (axi_reset || stat_clear) begin
         stat_pkt_cnt  <= '0;
         stat_drop_cnt <= '0;
      end else begin
         if (pkt_inc && stat_pkt_cnt != '1) stat_pkt_cnt <= stat_pkt_cnt + 1'b1;
         if (drop_inc && stat_drop_cnt != '1) stat_drop_cnt <= stat_drop_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_header_tuple_extractor.sv
// Scoreboard bench for header_tuple_extractor: directed packets, expected beats queued at issue.
module tb_header_tuple_extractor;

   localparam int W  = 256;
   localparam int SW = 32;
   localparam int TU = 128;
   localparam int CW = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic [W-1:0]   s_tdata;
   logic [SW-1:0]  s_tstrb;
   logic [TU-1:0]  s_tuser;
   logic           s_tvalid, s_tlast, s_tready;
   logic [W-1:0]   m_tdata;
   logic [SW-1:0]  m_tstrb;
   logic [TU-1:0]  m_tuser;
   logic           m_tvalid, m_tlast, m_tready;
   logic [103:0]   hdr_tuple;
   logic           hdr_valid;
   logic           cfg_drop, stat_clear;
   logic [CW-1:0]  pkt_cnt, drop_cnt;

   header_tuple_extractor #(
      .C_S_AXIS_DATA_WIDTH (W),
      .C_S_AXIS_TUSER_WIDTH(TU),
      .CNT_WIDTH           (CW)
   ) dut (
      .axi_aclk       (clk),
      .axi_reset      (rst),
      .s_axis_tdata   (s_tdata),
      .s_axis_tstrb   (s_tstrb),
      .s_axis_tuser   (s_tuser),
      .s_axis_tvalid  (s_tvalid),
      .s_axis_tlast   (s_tlast),
      .s_axis_tready  (s_tready),
      .m_axis_tdata   (m_tdata),
      .m_axis_tstrb   (m_tstrb),
      .m_axis_tuser   (m_tuser),
      .m_axis_tvalid  (m_tvalid),
      .m_axis_tlast   (m_tlast),
      .m_axis_tready  (m_tready),
      .m_hdr_tuple    (hdr_tuple),
      .m_hdr_valid    (hdr_valid),
      .cfg_drop_non_ip(cfg_drop),
      .stat_clear     (stat_clear),
      .stat_pkt_cnt   (pkt_cnt),
      .stat_drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0]  data;
      logic [SW-1:0] strb;
      logic [TU-1:0] user;
      logic          last;
      logic          hv;
      logic [103:0]  tuple;
   } beat_t;

   typedef struct {
      int           kind;   // 0 IPv4, 1 ARP, 2 VLAN+IPv4, 3 IPv4 with IHL=6
      int           len;
      logic [31:0]  sip, dip;
      logic [7:0]   proto;
      logic [15:0]  sp, dp;
      logic [103:0] tup;
   } tmpl_t;

   beat_t         exp_q[$];
   tmpl_t         tbl[8];
   int            n_cmp = 0;
   int            n_err = 0;
   logic          rand_rdy = 1'b0;
   logic [7:0]    pb[256];
   logic [TU-1:0] pkt_id = '0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Monitor: pops one expected beat per output handshake; checks stall stability.
   beat_t         e;
   logic          stall_q = 1'b0;
   beat_t         held_q;
   always @(negedge clk) begin
      if (rst) begin
         stall_q <= 1'b0;
      end else begin
         if (stall_q) begin
            check("stall_valid", W'(m_tvalid), W'(1));
            check("stall_data", m_tdata, held_q.data);
            check("stall_ctrl", {m_tstrb, m_tlast, m_tuser}, {held_q.strb, held_q.last, held_q.user});
            check("stall_hdr", {hdr_valid, hdr_tuple}, {held_q.hv, held_q.tuple});
         end
         stall_q <= m_tvalid && !m_tready;
         held_q  <= '{data: m_tdata, strb: m_tstrb, user: m_tuser, last: m_tlast,
                      hv: hdr_valid, tuple: hdr_tuple};
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_beat: got data %h, required no beat", m_tdata);
            end else begin
               e = exp_q.pop_front();
               check("out_data", m_tdata, e.data);
               check("out_ctrl", {m_tstrb, m_tlast, m_tuser}, {e.strb, e.last, e.user});
               check("hdr_valid", W'(hdr_valid), W'(e.hv));
               if (e.hv) check("hdr_tuple", W'(hdr_tuple), W'(e.tuple));
            end
         end
      end
   end

   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1 m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic build(input int t);
      int o;
      for (int i = 0; i < 256; i++) pb[i] = 8'(i * 13 + 5);
      o = (tbl[t].kind == 2) ? 4 : 0;
      if (tbl[t].kind == 1) begin
         pb[12] = 8'h08; pb[13] = 8'h06;
      end else begin
         if (tbl[t].kind == 2) begin
            pb[12] = 8'h81; pb[13] = 8'h00; pb[14] = 8'h00; pb[15] = 8'h05;
         end
         pb[12+o] = 8'h08; pb[13+o] = 8'h00;
         pb[14+o] = (tbl[t].kind == 3) ? 8'h46 : 8'h45;
         pb[23+o] = tbl[t].proto;
         for (int k = 0; k < 4; k++) begin
            pb[26+o+k] = tbl[t].sip[31-8*k -: 8];
            pb[30+o+k] = tbl[t].dip[31-8*k -: 8];
         end
         pb[34+o] = tbl[t].sp[15:8]; pb[35+o] = tbl[t].sp[7:0];
         pb[36+o] = tbl[t].dp[15:8]; pb[37+o] = tbl[t].dp[7:0];
      end
   endtask

   // Sends template t; max_beats < total truncates the packet (no expectation pushed).
   task automatic send(input int t, input int max_beats);
      int            len, nb, to, idx;
      logic          drop;
      logic [W-1:0]  d;
      logic [SW-1:0] s;
      beat_t         b;
      build(t);
      len    = tbl[t].len;
      nb     = (len + SW - 1) / SW;
      drop   = cfg_drop && (tbl[t].tup == '0);
      pkt_id = pkt_id + 1'b1;
      @(posedge clk);
      #1;
      for (int bi = 0; bi < nb && bi < max_beats; bi++) begin
         d = '0;
         s = '0;
         for (int j = 0; j < SW; j++) begin
            idx = bi * SW + j;
            if (idx < len) begin
               d[W-1-8*j -: 8] = pb[idx];
               s[SW-1-j]       = 1'b1;
            end
         end
         if (!drop && max_beats >= nb) begin
            b = '{data: d, strb: s, user: pkt_id, last: (bi == nb - 1), hv: (bi == 0),
                  tuple: tbl[t].tup};
            exp_q.push_back(b);
         end
         s_tdata  = d;
         s_tstrb  = s;
         s_tuser  = pkt_id;
         s_tlast  = (bi == nb - 1);
         s_tvalid = 1'b1;
         to = 0;
         @(negedge clk);
         while (!s_tready && to < 2000) begin
            @(negedge clk);
            to++;
         end
         if (to >= 2000) begin
            n_cmp++;
            n_err++;
            $display("FAIL drive_timeout: got tready 0 for %0d cycles, required 1", to);
         end
         @(posedge clk);
         #1;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 5000) begin
         @(posedge clk);
         t++;
      end
      repeat (6) @(posedge clk);
      #1;
      check("drain_left", W'(exp_q.size()), W'(0));
   endtask

   task automatic check_cnt(input string name, input int pkts, input int drops);
      @(negedge clk);
      check({name, "_pkt"}, W'(pkt_cnt), W'(pkts));
      check({name, "_drop"}, W'(drop_cnt), W'(drops));
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_clear();
      stat_clear = 1'b1;
      @(posedge clk);
      #1 stat_clear = 1'b0;
   endtask

   initial begin
      int exp_drops;
      tbl[0] = '{0, 96, 32'h0A000001, 32'h0A000002, 8'd6, 16'd1234, 16'd80,
                 104'h0A000001_0A000002_06_04D2_0050};
      tbl[1] = '{1, 60, 32'h0, 32'h0, 8'd0, 16'd0, 16'd0, 104'h0};
      tbl[2] = '{0, 64, 32'hC0A8010A, 32'hE00000FB, 8'd17, 16'd5353, 16'd5353,
                 104'hC0A8010A_E00000FB_11_14E9_14E9};
      tbl[3] = '{0, 70, 32'h01020304, 32'h05060708, 8'd1, 16'd7, 16'd9,
                 104'h01020304_05060708_01_0000_0000};
      tbl[4] = '{0, 30, 32'h0A000001, 32'h0A000002, 8'd17, 16'd1, 16'd2, 104'h0};
`ifdef HDR_VLAN_EN
      tbl[5] = '{2, 100, 32'hAC100001, 32'hAC100002, 8'd6, 16'd443, 16'd50000,
                 104'hAC100001_AC100002_06_01BB_C350};
      exp_drops = 18;
`else
      tbl[5] = '{2, 100, 32'hAC100001, 32'hAC100002, 8'd6, 16'd443, 16'd50000, 104'h0};
      exp_drops = 24;
`endif
      tbl[6] = '{3, 64, 32'h0A000001, 32'h0A000002, 8'd6, 16'd1, 16'd2, 104'h0};
      tbl[7] = '{0, 38, 32'h08080808, 32'h09090909, 8'd6, 16'd53, 16'd1024,
                 104'h08080808_09090909_06_0035_0400};

      rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tstrb = '0; s_tuser = '0;
      cfg_drop = 1'b0; stat_clear = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_s_tready", W'(s_tready), W'(1));
      check("rst_m_tvalid", W'(m_tvalid), W'(0));
      check("rst_hdr", {hdr_valid, hdr_tuple}, '0);
      check("rst_m_data", {m_tdata}, '0);
      check("rst_cnts", {pkt_cnt, drop_cnt}, '0);

      send(0, 99); drain(); check_cnt("tcp", 1, 0);
      pulse_clear(); check_cnt("clear1", 0, 0);
      cfg_drop = 1'b1;
      send(1, 99); drain(); check_cnt("arp_drop", 1, 1);
      cfg_drop = 1'b0;
      send(1, 99); send(3, 99); send(2, 99); send(4, 99);
      send(6, 99); send(7, 99); send(5, 99);
      drain(); check_cnt("mixed", 8, 1);

      pulse_clear();
      rand_rdy = 1'b1;
      for (int i = 0; i < 48; i++) send(i % 8, 99);
      drain();
      cfg_drop = 1'b1;
      for (int i = 0; i < 48; i++) send(i % 8, 99);
      drain();
      rand_rdy = 1'b0;
      @(posedge clk);
      #1;
      check_cnt("random", 96, exp_drops);

      // Clear held across the tlast handshake must win over the increment.
      cfg_drop = 1'b0;
      stat_clear = 1'b1;
      send(4, 99);
      stat_clear = 1'b0;
      drain(); check_cnt("clear_wins", 0, 0);

      // Reset mid-packet: the partial header is discarded and the next beat starts a packet.
      send(0, 1);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      send(0, 99); drain(); check_cnt("mid_reset", 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
